dco_tune_ctrl: RTL and testbench
================================

DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 Parameter WIDTH, 32, tuning-word width; matches the DCO phase accumulator.
REQ-002 Parameter PRESCALE, 4, sys_clk cycles between slew updates; legal range 1..65535.
REQ-003 Parameter SETTLE_CYC, 8, hold cycles after the target is reached and before done; legal range 1..65535.
REQ-004 Parameter INIT_WORD, 0, tuning_word value in reset.
REQ-005 Parameter MIN_WORD, 0, lower clamp bound; used only with DCO_TUNE_CLAMP_EN.
REQ-006 Parameter MAX_WORD, all-ones, upper clamp bound; used only with DCO_TUNE_CLAMP_EN.
REQ-007 sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 tgt_valid  in  1  new target request.
REQ-010 tgt_ready  out  1  controller can accept a target.
REQ-011 tgt_word  in  WIDTH  requested tuning word.
REQ-012 step  in  WIDTH  maximum change per update; sampled at accept.
REQ-013 abort  in  1  stop slewing and hold the current word.
REQ-014 tuning_word  out  WIDTH  registered word driving the DCO.
REQ-015 busy  out  1  high in SLEW or SETTLE.
REQ-016 done  out  1  one-cycle pulse when settling completes.
REQ-017 clamped  out  1  one-cycle pulse when an accepted target was clamped.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SLEW and SETTLE.
REQ-019 tgt_ready SHALL be registered; high only in IDLE and low in every other state.
REQ-020 Accept occurs when tgt_valid and tgt_ready are both high; the controller latches tgt_word and step, clears the tick counter and enters SLEW next cycle.
REQ-021 In SLEW, a tick SHALL occur every PRESCALE cycles; the first tick is PRESCALE cycles after the accept edge.
REQ-022 On each tick, if |target - tuning_word| <= step, tuning_word SHALL take the target value and the FSM enters SETTLE; otherwise tuning_word moves by step toward the target.
REQ-023 Arithmetic SHALL be unsigned WIDTH-bit and SHALL never wrap; the compare-before-add rule guarantees no overshoot.
REQ-024 step==0 SHALL load the target directly on the first tick.
REQ-025 A target equal to the current word SHALL complete on the first tick with the word unchanged.
REQ-026 SETTLE SHALL last SETTLE_CYC cycles; done then pulses for one cycle and the FSM returns to IDLE in the same cycle.
REQ-027 abort in SLEW or SETTLE SHALL force IDLE next cycle, hold tuning_word and suppress done; abort has priority over a coincident tick.
REQ-028 abort in IDLE SHALL have no effect and SHALL NOT block a simultaneous accept.
REQ-029 tgt_valid outside IDLE SHALL be ignored; no queueing.

Reset
REQ-030 With rst_n low at a sys_clk edge, the state SHALL be IDLE, tuning_word INIT_WORD, tgt_ready/busy/done/clamped 0, and the counters 0.
REQ-031 Reset mid-slew SHALL discard the target without a done pulse; tgt_ready SHALL rise on the first edge after release.

Configuration
REQ-032 With DCO_TUNE_CLAMP_EN defined, an accepted target SHALL be clamped to [MIN_WORD, MAX_WORD] and clamped SHALL pulse in the cycle after the accept if clamping changed the value.
REQ-033 Without DCO_TUNE_CLAMP_EN, targets SHALL be used verbatim, clamped SHALL be tied to 0, and MIN_WORD/MAX_WORD SHALL be ignored.

Structure
REQ-034 Package dco_pkg SHALL hold the FSM state typedef, the default WIDTH and the default INIT_WORD.
REQ-035 The prescaler SHALL be the sub-module dco_tick_gen (inputs clear and enable; output a one-cycle tick).

Verification
REQ-036 Reset, then target 42949673 with step 10000000 from 0 -> tuning_word steps 10M, 20M, 30M, 40M, 42949673 at ticks 1-5; done pulses 8 cycles after the last update.
REQ-037 From 42949673, target 0 with step 0 -> tuning_word is 0 at the first tick; one done pulse.
REQ-038 From 0, target 85899346 with step 50000000, abort asserted together with the first tick -> tuning_word stays 0, FSM returns to IDLE, no done pulse.
REQ-039 tgt_valid held high while busy -> second word ignored; tgt_ready low until done; a later accept succeeds.
REQ-040 rst_n low for 1 cycle mid-SLEW -> tuning_word=INIT_WORD, no done; tgt_ready high on the first edge after release.
REQ-041 With DCO_TUNE_CLAMP_EN, MAX_WORD=50000000, target 85899346 -> clamped pulse and final tuning_word 50000000; without the macro -> final word 85899346 and clamped stays 0.

Source files
------------

// File: rtl/dco_pkg.sv
// Shared types and defaults for the DCO tuning-word slew controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dco_pkg;

    localparam int unsigned DCO_WIDTH = 32;
    localparam logic [DCO_WIDTH-1:0] DCO_INIT_WORD = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        SETTLE = 2'd2
    } dco_state_t;

endpackage

// File: rtl/dco_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE enabled cycles, restarted by clear.
// Latency: first tick PRESCALE edges after the clear edge.
// Backpressure: none; enable simply freezes the count.
//
// Ports:
//   sys_clk, rst_n : clock and synchronous active-low reset
//   clear          : restart the count from zero (wins over enable)
//   enable         : count this cycle
//   tick           : combinational pulse in the cycle whose edge completes a period
module dco_tick_gen #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && !clear && (cnt == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dco_tune_ctrl.sv
// Slews the DCO tuning word toward a requested target in bounded steps, then settles.
// Latency: first update PRESCALE cycles after accept; done SETTLE_CYC cycles after the final update.
// Backpressure: tgt_ready is high only in IDLE; requests outside IDLE are dropped, not queued.
//
// Ports:
//   sys_clk, rst_n         : clock and synchronous active-low reset
//   tgt_valid/tgt_ready    : target handshake; tgt_word and step captured on accept
//   abort                  : leave SLEW/SETTLE at once, word held, no done
//   tuning_word            : registered word driving the DCO
//   busy, done, clamped    : status; done and clamped are one-cycle pulses
// Optional feature: define DCO_TUNE_CLAMP_EN to clamp targets to [MIN_WORD, MAX_WORD].
module dco_tune_ctrl
    import dco_pkg::*;
#(
    parameter int unsigned        WIDTH      = DCO_WIDTH,
    parameter int unsigned        PRESCALE   = 4,
    parameter int unsigned        SETTLE_CYC = 8,
    parameter logic [WIDTH-1:0]   INIT_WORD  = WIDTH'(DCO_INIT_WORD),
    parameter logic [WIDTH-1:0]   MIN_WORD   = '0,
    parameter logic [WIDTH-1:0]   MAX_WORD   = '1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_word,
    input  logic [WIDTH-1:0] step,
    input  logic             abort,
    output logic [WIDTH-1:0] tuning_word,
    output logic             busy,
    output logic             done,
    output logic             clamped
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

    dco_state_t       state_q;
    dco_state_t       next_state;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] step_q;
    logic [15:0]      settle_cnt;

    logic             accept;
    logic             tick;
    logic [WIDTH-1:0] tgt_eff;
    logic             clamp_hit;
    logic [WIDTH-1:0] diff;
    logic             reach;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] word_nxt;
    logic             settle_fin;

    assign accept = tgt_valid && tgt_ready;
    assign busy   = (state_q != IDLE);

`ifdef DCO_TUNE_CLAMP_EN
    always_comb begin
        tgt_eff   = tgt_word;
        clamp_hit = 1'b0;
        if (tgt_word < MIN_WORD) begin
            tgt_eff   = MIN_WORD;
            clamp_hit = 1'b1;
        end else if (tgt_word > MAX_WORD) begin
            tgt_eff   = MAX_WORD;
            clamp_hit = 1'b1;
        end
    end
`else
    // Bounds are ignored in this build; targets pass through untouched.
    assign tgt_eff   = tgt_word;
    assign clamp_hit = 1'b0;
`endif

    dco_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (state_q == SLEW),
        .tick    (tick)
    );

    // Distance is checked before stepping, so a step never crosses the
    // target and the add/subtract below can never wrap.
    always_comb begin
        diff    = (target_q >= tuning_word) ? (target_q - tuning_word)
                                            : (tuning_word - target_q);
        reach   = (step_q == '0) || (diff <= step_q);
        stepped = (target_q > tuning_word) ? (tuning_word + step_q)
                                           : (tuning_word - step_q);
    end

    always_comb begin
        next_state = state_q;
        word_nxt   = tuning_word;
        settle_fin = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    next_state = SLEW;
                end
            end
            SLEW: begin
                // abort outranks a coincident tick: the word is left as is
                if (abort) begin
                    next_state = IDLE;
                end else if (tick) begin
                    if (reach) begin
                        word_nxt   = target_q;
                        next_state = SETTLE;
                    end else begin
                        word_nxt   = stepped;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    next_state = IDLE;
                    settle_fin = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tuning_word <= INIT_WORD;
            target_q    <= '0;
            step_q      <= '0;
            settle_cnt  <= '0;
            tgt_ready   <= 1'b0;
            done        <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            state_q     <= next_state;
            tuning_word <= word_nxt;
            tgt_ready   <= (next_state == IDLE);
            done        <= settle_fin;
            clamped     <= accept && clamp_hit;
            if (accept) begin
                target_q <= tgt_eff;
                step_q   <= step;
            end
            if ((state_q == SETTLE) && (next_state == SETTLE)) begin
                settle_cnt <= settle_cnt + 16'd1;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Self-checking bench for dco_tune_ctrl (default build, clamp disabled).
// Word updates are checked against a scoreboard queue filled by a reference model.
// Table vectors cover slews up/down, step edge cases; hand sequences cover abort, held valid and reset.
module tb_dco_tune_ctrl;

    localparam int PRESCALE   = 4;
    localparam int SETTLE_CYC = 8;

    logic        sys_clk;
    logic        rst_n;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [31:0] tgt_word;
    logic [31:0] step;
    logic        abort;
    logic [31:0] tuning_word;
    logic        busy;
    logic        done;
    logic        clamped;

    dco_tune_ctrl #(
        .WIDTH      (32),
        .PRESCALE   (PRESCALE),
        .SETTLE_CYC (SETTLE_CYC),
        .INIT_WORD  (32'd0),
        .MIN_WORD   (32'd0),
        .MAX_WORD   (32'd50000000)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .tgt_valid   (tgt_valid),
        .tgt_ready   (tgt_ready),
        .tgt_word    (tgt_word),
        .step        (step),
        .abort       (abort),
        .tuning_word (tuning_word),
        .busy        (busy),
        .done        (done),
        .clamped     (clamped)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] stp;
        bit          abort_at_accept;
        int          exp_changes;
        logic [31:0] exp_final;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_q [$];
    int          checks;
    int          failures;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          n_changes;
    bit          clamp_seen;
    logic [31:0] prev_word;
    logic [31:0] model_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle; all DUT observation happens on the falling edge.
    task automatic step_cyc();
        @(negedge sys_clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (clamped !== 1'b0) clamp_seen = 1'b1;
        if (tuning_word !== prev_word) begin
            n_changes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word_unexpected: got %0d expected no change from %0d",
                         tuning_word, prev_word);
            end else begin
                chk("word_update", tuning_word, exp_q.pop_front());
            end
            prev_word = tuning_word;
        end
    endtask

    // Reference slew: pushes every expected word change, returns tick count.
    task automatic model_push(input logic [31:0] tgt, input logic [31:0] stp, output int ticks);
        logic [31:0] w;
        logic [31:0] d;
        w     = model_word;
        ticks = 0;
        do begin
            ticks++;
            d = (tgt >= w) ? tgt - w : w - tgt;
            if (stp == 32'd0 || d <= stp) begin
                if (w != tgt) exp_q.push_back(tgt);
                w = tgt;
            end else begin
                w = (tgt > w) ? w + stp : w - stp;
                exp_q.push_back(w);
            end
        end while (w != tgt);
        model_word = w;
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (tgt_ready !== 1'b1 && waited < 50) begin
            step_cyc();
            waited++;
        end
        chk("ready_before_accept", 32'(tgt_ready), 32'd1);
    endtask

    task automatic wait_done(input int base_done);
        int waited;
        waited = 0;
        while (done_cnt == base_done && waited < 3000) begin
            step_cyc();
            waited++;
        end
        chk("done_seen", 32'(done_cnt - base_done), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int ticks;
        int base_done;
        int acc_cyc;
        wait_ready();
        base_done  = done_cnt;
        n_changes  = 0;
        tgt_word   = v.tgt;
        step       = v.stp;
        tgt_valid  = 1'b1;
        abort      = v.abort_at_accept;
        model_push(v.tgt, v.stp, ticks);
        step_cyc();
        acc_cyc    = cyc;
        tgt_valid  = 1'b0;
        abort      = 1'b0;
        chk($sformatf("v%0d_busy_after_accept", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d_ready_low", idx), 32'(tgt_ready), 32'd0);
        wait_done(base_done);
        chk($sformatf("v%0d_done_latency", idx), 32'(done_cyc - acc_cyc),
            32'(ticks * PRESCALE + SETTLE_CYC));
        chk($sformatf("v%0d_final_word", idx), tuning_word, v.exp_final);
        chk($sformatf("v%0d_changes", idx), 32'(n_changes), 32'(v.exp_changes));
        chk($sformatf("v%0d_sb_drained", idx), 32'(exp_q.size()), 32'd0);
        step_cyc();
        chk($sformatf("v%0d_done_one_cycle", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_ready_after_done", idx), 32'(tgt_ready), 32'd1);
    endtask

    initial begin
        int base_done;
        int ticks;
        bit ready_leak;
        int waited;

        vecs[0] = '{32'd42949673, 32'd10000000, 1'b0, 5, 32'd42949673};
        vecs[1] = '{32'd0,        32'd0,        1'b0, 1, 32'd0};
        vecs[2] = '{32'd0,        32'd5,        1'b0, 0, 32'd0};
        vecs[3] = '{32'd1000,     32'd300,      1'b1, 4, 32'd1000};
        vecs[4] = '{32'd100,      32'd300,      1'b0, 3, 32'd100};
        vecs[5] = '{32'hFFFF_FFF0, 32'h8000_0000, 1'b0, 2, 32'hFFFF_FFF0};
        vecs[6] = '{32'd5,        32'hFFFF_FFFF, 1'b0, 1, 32'd5};
        vecs[7] = '{32'd85899346, 32'd50000000, 1'b0, 2, 32'd85899346};

        checks     = 0;
        failures   = 0;
        cyc        = 0;
        done_cnt   = 0;
        done_cyc   = 0;
        n_changes  = 0;
        clamp_seen = 1'b0;
        prev_word  = 32'd0;
        model_word = 32'd0;
        rst_n      = 1'b0;
        tgt_valid  = 1'b0;
        tgt_word   = 32'd0;
        step       = 32'd0;
        abort      = 1'b0;

        // Reset state
        repeat (3) step_cyc();
        chk("rst_word", tuning_word, 32'd0);
        chk("rst_ready", 32'(tgt_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clamped", 32'(clamped), 32'd0);
        rst_n = 1'b1;
        step_cyc();
        chk("ready_first_edge", 32'(tgt_ready), 32'd1);

        // Abort coincident with the first tick: word stays, no done
        base_done = done_cnt;
        tgt_word  = 32'd85899346;
        step      = 32'd50000000;
        tgt_valid = 1'b1;
        step_cyc();
        tgt_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        repeat (PRESCALE - 1) step_cyc();
        abort = 1'b1;
        step_cyc();
        abort = 1'b0;
        chk("abort_word", tuning_word, 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tgt_ready), 32'd1);
        repeat (40) step_cyc();
        chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end
        chk("clamped_never", 32'(clamp_seen), 32'd0);

        // tgt_valid held high while busy: second word ignored until done
        wait_ready();
        base_done  = done_cnt;
        tgt_word   = 32'd7777;
        step       = 32'd0;
        tgt_valid  = 1'b1;
        model_push(32'd7777, 32'd0, ticks);
        step_cyc();
        tgt_word   = 32'd12345;
        ready_leak = 1'b0;
        waited     = 0;
        while (done_cnt == base_done && waited < 200) begin
            step_cyc();
            waited++;
            if (done !== 1'b1 && tgt_ready !== 1'b0) ready_leak = 1'b1;
        end
        chk("held_done", 32'(done_cnt - base_done), 32'd1);
        chk("held_ready_low", 32'(ready_leak), 32'd0);
        chk("held_first_word", tuning_word, 32'd7777);
        model_push(32'd12345, 32'd0, ticks);
        base_done = done_cnt;
        step_cyc();
        tgt_valid = 1'b0;
        chk("held_second_accept", 32'(busy), 32'd1);
        wait_done(base_done);
        chk("held_second_word", tuning_word, 32'd12345);
        chk("held_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset for one cycle in the middle of a slew
        wait_ready();
        base_done = done_cnt;
        tgt_word  = 32'd112345;
        step      = 32'd1000;
        tgt_valid = 1'b1;
        exp_q.push_back(32'd13345);
        exp_q.push_back(32'd14345);
        exp_q.push_back(32'd0);
        step_cyc();
        tgt_valid = 1'b0;
        repeat (2 * PRESCALE + 1) step_cyc();
        rst_n = 1'b0;
        step_cyc();
        chk("mid_rst_word", tuning_word, 32'd0);
        chk("mid_rst_ready", 32'(tgt_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step_cyc();
        chk("mid_rst_ready_rise", 32'(tgt_ready), 32'd1);
        repeat (60) step_cyc();
        chk("mid_rst_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("mid_rst_sb_drained", 32'(exp_q.size()), 32'd0);
        model_word = 32'd0;

        // A fresh target after reset completes normally
        run_vec('{32'd500, 32'd200, 1'b0, 3, 32'd500}, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
